solver: RTL and testbench
=========================

Name: solver

Overview:
- Line-elimination core of the nonogram solver. It consumes a stream of words from the options FIFO. Each line is sent as a line-index word followed by that line's candidate fill patterns ("options").
- It discards options that contradict already-known cells and writes surviving options back to the FIFO.
- It marks a cell known once every surviving option of a line agrees on it. It flags solved when the whole board is known.

Parameters:
- SIZE, 11, maximum board side. known/assigned are SIZE*SIZE bits; old_options_amnt has 2*SIZE entries.
- OPT_W, 16, width of option/new_option words.
- CNT_W, 7, width of each per-line option count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- started  in  1  one-cycle pulse: board loaded, begin solving.
- option  in  16  current FIFO word; either a line index or an option pattern.
- num_rows  in  4  active rows (1..SIZE).
- num_cols  in  4  active columns (1..SIZE).
- old_options_amnt  in  2*SIZE x 7  number of options queued for each line index.
- new_line  out  1  high in the cycle a line-index word is consumed.
- new_option  out  16  word to write back to the FIFO.
- put_back_to_FIFO  out  1  write strobe for new_option.
- assigned  out  SIZE*SIZE  cell values, valid where known=1. Cell (r,c) is bit r*num_cols+c.
- known  out  SIZE*SIZE  cell-known flags.
- solved  out  1  all num_rows*num_cols cells known.

Behaviour:
- Reset (sync, highest priority, any state): state=IDLE, known=0, assigned=0, solved=0, new_line=0, put_back_to_FIFO=0, new_option=0, accumulators cleared.
- Line indexing:
  - Indices 0..num_rows-1 are rows r.
  - Indices num_rows..num_rows+num_cols-1 are columns c=idx-num_rows.
  - Line length L = num_cols for rows, num_rows for columns.
  - Option bit (L-1-k) is line cell k, so the MSB is the leftmost/topmost cell.
  - Row cell k maps to (r,k); column cell k maps to (k,c).
- IDLE: wait for started=1, then go to INDEX.
- INDEX (1 cycle per line):
  - Latch option as idx; latch remaining = old_options_amnt[idx]; clear and_acc to all-1s, or_acc to 0, valid_cnt to 0.
  - Assert new_line=1, put_back_to_FIFO=1, new_option=idx (the index is re-queued).
  - If remaining==0, stay in INDEX; otherwise go to CHECK.
- CHECK (cycle 1 of each option):
  - Latch option.
  - The option is consistent iff, for every cell k with known=1, option bit equals assigned.
  - Go to UPDATE.
- UPDATE (cycle 2 of each option):
  - If consistent: and_acc&=opt, or_acc|=opt, valid_cnt++, put_back_to_FIFO=1, new_option=opt.
  - If inconsistent: no write, option dropped.
  - remaining--.
  - If remaining becomes 0, commit, then go to INDEX (or IDLE if solved). Otherwise go to CHECK.
- Commit (same edge as the last UPDATE, using accumulators that include the last option):
  - If valid_cnt_final>0, for each cell k<L: and_acc bit 1 -> known=1, assigned=1; or_acc bit 0 -> known=1, assigned=0.
  - Already-known cells are never changed.
  - If valid_cnt_final==0 (contradiction), no update.
- Output timing:
  - new_line/put_back_to_FIFO are single-cycle strobes, otherwise 0.
  - new_option holds its last value when the strobe is low.
- Bits beyond num_rows*num_cols stay 0 in known/assigned.
- solved is registered:
  - Set the cycle after the commit that makes all active cells known.
  - Remains 1 until reset.
  - FSM returns to IDLE once solved.
- started while not IDLE is ignored.
- Index values >= num_rows+num_cols: treated as count 0 (skipped, no board update).

Test Plan:
- Reset -> known=0, assigned=0, solved=0, new_line=0, put_back_to_FIFO=0.
- 11x11, all counts=1. After started: index 0 (1 cycle), then option 11'b11111111111 (2 cycles) -> known[10:0]=all 1, assigned[10:0]=all 1; new_line pulses with new_option=0, then put_back strobes 11'b11111111111.
- Continue rows 1..10 with the X-board patterns (row1=10111111101, ...) -> after row 10 all 121 known, assigned equals the X board, solved=1 one cycle later.
- Known row0=all 1, then column 0 option with MSB 0 -> option dropped (no put_back), no board change.
- Line with 2 options 11100000000 and 01110000000 -> cells 1,2 known=1; cells 4..10 known=0-valued; cells 0,3 unknown; both options put back.
- Reset mid-line (during CHECK) -> all outputs return to reset values; next started restarts cleanly.

Source files
------------

// File: rtl/solver.sv
// Line-elimination core: filters a line's options against known cells, re-queues
// the survivors and marks cells known where every surviving option agrees.
module solver #(
   parameter int unsigned SIZE  = 11,
   parameter int unsigned OPT_W = 16,
   parameter int unsigned CNT_W = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 started,
   input  logic [OPT_W-1:0]     option,
   input  logic [3:0]           num_rows,
   input  logic [3:0]           num_cols,
   input  logic [CNT_W-1:0]     old_options_amnt [2*SIZE],
   output logic                 new_line,
   output logic [OPT_W-1:0]     new_option,
   output logic                 put_back_to_FIFO,
   output logic [SIZE*SIZE-1:0] assigned,
   output logic [SIZE*SIZE-1:0] known,
   output logic                 solved
);

   localparam int unsigned CELLS  = SIZE * SIZE;
   localparam int unsigned LINES  = 2 * SIZE;
   localparam int unsigned CELL_W = $clog2(CELLS);
   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned POS_W  = $clog2(OPT_W);
   localparam int unsigned AREA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      INDEX,
      CHECK,
      UPDATE
   } state_t;

   state_t             state_q, state_d;
   logic [OPT_W-1:0]   idx_q;
   logic [CNT_W-1:0]   remaining_q;
   logic [OPT_W-1:0]   and_q, or_q, opt_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               consistent_q;
   logic               full_pend_q;

   logic               new_line_d, put_back_d;
   logic [OPT_W-1:0]   new_option_d;

   logic               is_row_c;
   logic [CELL_W-1:0]  rows_w, cols_w, sel_w, len_w;
   logic [CELL_W-1:0]  cell_c [SIZE];
   logic [POS_W-1:0]   pos_c  [SIZE];
   logic [SIZE-1:0]    in_line_c;
   logic [AREA_W-1:0]  area_c;
   logic [CELLS-1:0]   active_c;

   logic [CNT_W-1:0]   amnt_c;
   logic               consistent_c;
   logic               take_c, last_c, full_nxt_c;
   logic [OPT_W-1:0]   and_nxt, or_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [CELLS-1:0]   known_nxt, assigned_nxt;

   // Map each line cell k to its board cell and its option bit position.
   always_comb begin : line_decode
      rows_w   = CELL_W'(num_rows);
      cols_w   = CELL_W'(num_cols);
      is_row_c = idx_q < OPT_W'(num_rows);
      sel_w    = is_row_c ? CELL_W'(idx_q) : CELL_W'(idx_q) - rows_w;
      len_w    = is_row_c ? cols_w : rows_w;
      for (int unsigned k = 0; k < SIZE; k++) begin
         in_line_c[k] = CELL_W'(k) < len_w;
         cell_c[k]    = is_row_c ? (sel_w * cols_w + CELL_W'(k))
                                 : (CELL_W'(k) * cols_w + sel_w);
         pos_c[k]     = POS_W'(len_w - CELL_W'(1) - CELL_W'(k));
      end
   end

   always_comb begin : active_area
      area_c = AREA_W'(num_rows) * AREA_W'(num_cols);
      for (int unsigned i = 0; i < CELLS; i++) begin
         active_c[i] = AREA_W'(i) < area_c;
      end
   end

   // Out-of-range indices read as an empty line.
   always_comb begin : amount_lookup
      amnt_c = '0;
      if ((option < (OPT_W'(num_rows) + OPT_W'(num_cols))) && (option < OPT_W'(LINES))) begin
         amnt_c = old_options_amnt[option[IDX_W-1:0]];
      end
   end

   always_comb begin : consistency
      consistent_c = 1'b1;
      for (int unsigned k = 0; k < SIZE; k++) begin
         if (in_line_c[k] && known[cell_c[k]] && (option[pos_c[k]] != assigned[cell_c[k]])) begin
            consistent_c = 1'b0;
         end
      end
   end

   // Accumulators including the option in flight, and the board after commit.
   always_comb begin : commit_calc
      take_c       = (state_q == UPDATE) && consistent_q;
      last_c       = (state_q == UPDATE) && (remaining_q == CNT_W'(1));
      and_nxt      = take_c ? (and_q & opt_q) : and_q;
      or_nxt       = take_c ? (or_q | opt_q) : or_q;
      cnt_nxt      = take_c ? (cnt_q + CNT_W'(1)) : cnt_q;
      known_nxt    = known;
      assigned_nxt = assigned;
      if (last_c && (cnt_nxt != '0)) begin
         for (int unsigned k = 0; k < SIZE; k++) begin
            if (in_line_c[k] && !known[cell_c[k]]) begin
               if (and_nxt[pos_c[k]]) begin
                  known_nxt[cell_c[k]]    = 1'b1;
                  assigned_nxt[cell_c[k]] = 1'b1;
               end else if (!or_nxt[pos_c[k]]) begin
                  known_nxt[cell_c[k]]    = 1'b1;
                  assigned_nxt[cell_c[k]] = 1'b0;
               end
            end
         end
      end
      full_nxt_c = &(known_nxt | ~active_c);
   end

   always_comb begin : fsm_next
      state_d      = state_q;
      new_line_d   = 1'b0;
      put_back_d   = 1'b0;
      new_option_d = new_option;
      case (state_q)
         IDLE: begin
            if (started && !solved) state_d = INDEX;
         end
         INDEX: begin
            new_line_d   = 1'b1;
            put_back_d   = 1'b1;
            new_option_d = option;
            state_d      = (amnt_c == '0) ? INDEX : CHECK;
         end
         CHECK: begin
            state_d = UPDATE;
         end
         UPDATE: begin
            if (take_c) begin
               put_back_d   = 1'b1;
               new_option_d = opt_q;
            end
            if (last_c) state_d = full_nxt_c ? IDLE : INDEX;
            else        state_d = CHECK;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : regs
      if (rst) begin
         state_q          <= IDLE;
         idx_q            <= '0;
         remaining_q      <= '0;
         and_q            <= '1;
         or_q             <= '0;
         cnt_q            <= '0;
         opt_q            <= '0;
         consistent_q     <= 1'b0;
         full_pend_q      <= 1'b0;
         new_line         <= 1'b0;
         put_back_to_FIFO <= 1'b0;
         new_option       <= '0;
         known            <= '0;
         assigned         <= '0;
         solved           <= 1'b0;
      end else begin
         state_q          <= state_d;
         new_line         <= new_line_d;
         put_back_to_FIFO <= put_back_d;
         new_option       <= new_option_d;
         known            <= known_nxt;
         assigned         <= assigned_nxt;
         full_pend_q      <= last_c && full_nxt_c;
         solved           <= solved | full_pend_q;
         case (state_q)
            INDEX: begin
               idx_q       <= option;
               remaining_q <= amnt_c;
               and_q       <= '1;
               or_q        <= '0;
               cnt_q       <= '0;
            end
            CHECK: begin
               opt_q        <= option;
               consistent_q <= consistent_c;
            end
            UPDATE: begin
               and_q       <= and_nxt;
               or_q        <= or_nxt;
               cnt_q       <= cnt_nxt;
               remaining_q <= remaining_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_solver.sv
// Bench for solver: directed board scenarios plus random boards, checked
// against a cell-by-cell board model kept in the bench.
module tb_solver;
   localparam int unsigned SIZE  = 11;
   localparam int unsigned OPT_W = 16;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned CELLS = SIZE * SIZE;

   logic             clk = 1'b0;
   logic             rst;
   logic             started;
   logic [OPT_W-1:0] option;
   logic [3:0]       num_rows, num_cols;
   logic [CNT_W-1:0] amnt [2*SIZE];
   logic             new_line, put_back, solved;
   logic [OPT_W-1:0] new_option;
   logic [CELLS-1:0] assigned, known;

   int checks = 0;
   int errors = 0;
   bit mk  [SIZE][SIZE];
   bit mv  [SIZE][SIZE];
   bit sol [SIZE][SIZE];
   int nr, nc;
   bit done;
   logic [OPT_W-1:0] last_written;

   solver #(.SIZE(SIZE), .OPT_W(OPT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .started(started), .option(option),
      .num_rows(num_rows), .num_cols(num_cols), .old_options_amnt(amnt),
      .new_line(new_line), .new_option(new_option), .put_back_to_FIFO(put_back),
      .assigned(assigned), .known(known), .solved(solved)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int line_len(int idx);
      return (idx < nr) ? nc : nr;
   endfunction

   function automatic void cell_of(int idx, int k, output int r, output int c);
      if (idx < nr) begin r = idx; c = k; end
      else begin r = k; c = idx - nr; end
   endfunction

   function automatic logic [OPT_W-1:0] truth(int idx);
      logic [OPT_W-1:0] p = '0;
      int r, c, L;
      L = line_len(idx);
      for (int k = 0; k < L; k++) begin
         cell_of(idx, k, r, c);
         p[L-1-k] = sol[r][c];
      end
      return p;
   endfunction

   function automatic bit consistent(int idx, logic [OPT_W-1:0] opt);
      int r, c, L;
      L = line_len(idx);
      for (int k = 0; k < L; k++) begin
         cell_of(idx, k, r, c);
         if (mk[r][c] && (opt[L-1-k] != mv[r][c])) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [CELLS-1:0] exp_known();
      logic [CELLS-1:0] v = '0;
      for (int r = 0; r < nr; r++)
         for (int c = 0; c < nc; c++) v[r*nc+c] = mk[r][c];
      return v;
   endfunction

   function automatic logic [CELLS-1:0] exp_assigned();
      logic [CELLS-1:0] v = '0;
      for (int r = 0; r < nr; r++)
         for (int c = 0; c < nc; c++) v[r*nc+c] = mk[r][c] & mv[r][c];
      return v;
   endfunction

   function automatic bit model_full();
      for (int r = 0; r < nr; r++)
         for (int c = 0; c < nc; c++) if (!mk[r][c]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic set_dims(input int r, input int c);
      nr = r; nc = c;
      num_rows = 4'(r);
      num_cols = 4'(c);
   endtask

   task automatic do_reset();
      rst = 1'b1; started = 1'b0; option = '0;
      for (int i = 0; i < 2*SIZE; i++) amnt[i] = '0;
      step();
      rst = 1'b0;
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++) begin mk[r][c] = 1'b0; mv[r][c] = 1'b0; end
      done = 1'b0;
      last_written = '0;
   endtask

   task automatic start();
      started = 1'b1;
      step();
      started = 1'b0;
   endtask

   // Send one line (index word then its options) and check every strobe and the commit.
   task automatic run_line(input int idx, input logic [OPT_W-1:0] opts [$], input string tag);
      logic [OPT_W-1:0] surv [$];
      bit cons, all1, all0;
      int r, c, L;
      if (idx < 2*SIZE) amnt[idx] = CNT_W'(opts.size());
      option = OPT_W'(idx);
      step();
      chk($sformatf("%s/idx%0d new_line", tag, idx), CELLS'(new_line), CELLS'(1));
      chk($sformatf("%s/idx%0d put_back", tag, idx), CELLS'(put_back), CELLS'(1));
      chk($sformatf("%s/idx%0d new_option", tag, idx), CELLS'(new_option), CELLS'(idx));
      chk($sformatf("%s/idx%0d solved_low", tag, idx), CELLS'(solved), CELLS'(0));
      last_written = OPT_W'(idx);
      if (idx >= nr + nc || opts.size() == 0) begin
         chk($sformatf("%s/idx%0d known_unchanged", tag, idx), known, exp_known());
         return;
      end
      L = line_len(idx);
      foreach (opts[i]) begin
         cons = consistent(idx, opts[i]);
         option = opts[i];
         step();
         chk($sformatf("%s/idx%0d opt%0d check_strobe", tag, idx, i), CELLS'({new_line, put_back}), CELLS'(0));
         option = OPT_W'($urandom);
         step();
         chk($sformatf("%s/idx%0d opt%0d put_back", tag, idx, i), CELLS'(put_back), CELLS'(cons));
         if (cons) begin
            surv.push_back(opts[i]);
            last_written = opts[i];
         end
         chk($sformatf("%s/idx%0d opt%0d new_option", tag, idx, i), CELLS'(new_option), CELLS'(last_written));
      end
      if (surv.size() > 0) begin
         for (int k = 0; k < L; k++) begin
            cell_of(idx, k, r, c);
            if (!mk[r][c]) begin
               all1 = 1'b1; all0 = 1'b1;
               foreach (surv[j]) begin
                  if (surv[j][L-1-k]) all0 = 1'b0;
                  else                all1 = 1'b0;
               end
               if (all1)      begin mk[r][c] = 1'b1; mv[r][c] = 1'b1; end
               else if (all0) begin mk[r][c] = 1'b1; mv[r][c] = 1'b0; end
            end
         end
      end
      chk($sformatf("%s/idx%0d known", tag, idx), known, exp_known());
      chk($sformatf("%s/idx%0d assigned", tag, idx), assigned, exp_assigned());
      if (!done && model_full()) begin
         chk($sformatf("%s/idx%0d solved_not_yet", tag, idx), CELLS'(solved), CELLS'(0));
         step();
         chk($sformatf("%s/idx%0d solved", tag, idx), CELLS'(solved), CELLS'(1));
         done = 1'b1;
      end
   endtask

   initial begin
      logic [OPT_W-1:0] q [$];
      int n, pos, L;

      // Reset values
      set_dims(11, 11);
      rst = 1'b1; started = 1'b0; option = 16'h5a5a;
      for (int i = 0; i < 2*SIZE; i++) amnt[i] = CNT_W'(1);
      step(); step();
      chk("reset known", known, '0);
      chk("reset assigned", assigned, '0);
      chk("reset solved", CELLS'(solved), '0);
      chk("reset new_line", CELLS'(new_line), '0);
      chk("reset put_back", CELLS'(put_back), '0);
      chk("reset new_option", CELLS'(new_option), '0);

      // 11x11 X board, one option per row
      do_reset();
      set_dims(11, 11);
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            sol[r][c] = (r == 0) ? 1'b1 : !((c == r) || (c == 10 - r));
      start();
      for (int r = 0; r < 11; r++) begin
         q = {};
         q.push_back(truth(r));
         run_line(r, q, "xboard");
         if (r == 0) chk("xboard row0 known", CELLS'(known[10:0]), CELLS'(11'h7ff));
      end
      chk("xboard assigned_full", assigned, exp_assigned());
      option = '0;
      step();
      chk("xboard idle_after_solved", CELLS'(new_line), '0);
      started = 1'b1; step(); started = 1'b0; step();
      chk("xboard started_ignored", CELLS'({new_line, put_back}), '0);
      chk("xboard solved_sticky", CELLS'(solved), CELLS'(1));

      // Column option contradicting a known row cell is dropped
      do_reset();
      set_dims(11, 11);
      start();
      q = {16'h07ff};
      run_line(0, q, "drop");
      q = {16'h03ff};
      run_line(11, q, "drop");
      chk("drop board_unchanged", CELLS'(known[10:0]), CELLS'(11'h7ff));

      // Two overlapping options, then empty and out-of-range lines
      do_reset();
      set_dims(11, 11);
      start();
      q = {16'h0700, 16'h0380};
      run_line(0, q, "two");
      chk("two known_const", CELLS'(known[10:0]), CELLS'(11'h7f6));
      chk("two assigned_const", CELLS'(assigned[10:0]), CELLS'(11'h006));
      q = {};
      run_line(5, q, "empty");
      q = {16'h0001};
      run_line(30, q, "oob");
      q = {16'h0001};
      run_line(12, q, "after_skip");

      // Index within the count table but beyond the active lines is skipped
      do_reset();
      set_dims(3, 4);
      start();
      q = {16'h0003, 16'h0005};
      run_line(9, q, "small_oob");
      q = {16'h000f};
      run_line(0, q, "small");
      chk("small outside_area", CELLS'(known >> 12), '0);

      // Reset in the middle of a line
      do_reset();
      set_dims(11, 11);
      start();
      q = {16'h07ff};
      run_line(0, q, "midrst");
      amnt[1] = CNT_W'(2);
      option = 16'd1; step();
      option = 16'h07ff; rst = 1'b1; step();
      chk("midrst known", known, '0);
      chk("midrst assigned", assigned, '0);
      chk("midrst solved", CELLS'(solved), '0);
      chk("midrst strobes", CELLS'({new_line, put_back}), '0);
      chk("midrst new_option", CELLS'(new_option), '0);
      do_reset();
      set_dims(11, 11);
      start();
      q = {16'h0400, 16'h0401};
      run_line(1, q, "restart");

      // Random boards with the true pattern hidden among random options
      for (int run = 0; run < 6; run++) begin
         do_reset();
         set_dims(int'($urandom_range(1, 11)), int'($urandom_range(1, 11)));
         for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) sol[r][c] = 1'($urandom_range(0, 1));
         start();
         for (int pass = 0; pass < 12 && !done; pass++) begin
            for (int idx = 0; idx < nr + nc && !done; idx++) begin
               L = line_len(idx);
               n = int'($urandom_range(0, 3));
               pos = int'($urandom_range(0, n));
               q = {};
               for (int i = 0; i <= n; i++)
                  q.push_back((i == pos) ? truth(idx) : OPT_W'($urandom_range(0, (1 << L) - 1)));
               run_line(idx, q, $sformatf("rand%0d", run));
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
